scroll_scheduler: RTL

//  Per-frame sequencer for the sprite/background address transformer's

---
 rtl/scroll_scheduler_if.sv | 30 +++
 rtl/scroll_scheduler.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/scroll_scheduler_if.sv
// Control/offset bundle between game logic, VGA frame timing and the scroll scheduler.
// master drives the request side, slave (the scheduler) drives offsets and status.
interface scroll_scheduler_if #(
   parameter int HWIDTH  = 12,
   parameter int VWIDTH  = 12,
   parameter int SPEED_W = 4
);
   logic                      frame_start;
   logic                      start;
   logic                      pause;
   logic                      crash;
   logic                      lane_left;
   logic                      lane_right;
   logic signed [HWIDTH-1:0]  hoffset;
   logic signed [VWIDTH-1:0]  voffset;
   logic [SPEED_W-1:0]        speed;
   logic [1:0]                lane;
   logic [1:0]                state;
   logic [15:0]               frame_cnt;

   modport master (
      output frame_start, start, pause, crash, lane_left, lane_right,
      input  hoffset, voffset, speed, lane, state, frame_cnt
   );

   modport slave (
      input  frame_start, start, pause, crash, lane_left, lane_right,
      output hoffset, voffset, speed, lane, state, frame_cnt
   );
endinterface

// File: rtl/scroll_scheduler.sv
// Per-frame scroll sequencer: game FSM, forward scroll with speed ramp, lane slew on hoffset.
// Define SCROLL_WRAP_EN to keep voffset inside [0, VSPAN-1]; otherwise it free-runs.
module scroll_scheduler #(
   parameter int HWIDTH       = 12,
   parameter int VWIDTH       = 12,
   parameter int VSPAN        = 120,
   parameter int LANE_W       = 40,
   parameter int LANE_STEP    = 4,
   parameter int SPEED_W      = 4,
   parameter int SPEED_INIT   = 1,
   parameter int SPEED_MAX    = 8,
   parameter int ACCEL_FRAMES = 60
) (
   input logic                clk,
   input logic                rst,
   scroll_scheduler_if.slave  bus
);
   localparam int ACC_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

   localparam logic [SPEED_W-1:0]       SPEED_INIT_V = SPEED_W'(SPEED_INIT);
   localparam logic [SPEED_W-1:0]       SPEED_MAX_V  = SPEED_W'(SPEED_MAX);
   localparam logic [ACC_W-1:0]         ACC_LAST     = ACC_W'(ACCEL_FRAMES - 1);
   localparam logic signed [HWIDTH-1:0] LANE_W_V     = HWIDTH'(LANE_W);
   localparam logic signed [HWIDTH-1:0] STEP_V       = HWIDTH'(LANE_STEP);
   localparam logic signed [HWIDTH:0]   STEP_E       = (HWIDTH+1)'(LANE_STEP);
`ifdef SCROLL_WRAP_EN
   localparam logic signed [VWIDTH:0]   VSPAN_V      = (VWIDTH+1)'(VSPAN);
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_PAUSED = 2'd2,
      S_DEAD   = 2'd3
   } state_e;

   state_e                   state_q, state_d;
   logic signed [HWIDTH-1:0] hoff_q, hoff_d;
   logic signed [VWIDTH-1:0] voff_q, voff_d;
   logic [SPEED_W-1:0]       speed_q, speed_d;
   logic [1:0]               lane_q, lane_d;
   logic [15:0]              fcnt_q, fcnt_d;
   logic [ACC_W-1:0]         acc_q, acc_d;

   logic                     restart, frame_upd, lane_ok;
   logic signed [VWIDTH:0]   vdiff;
   logic signed [VWIDTH-1:0] vnext;
   logic signed [HWIDTH-1:0] target;
   logic signed [HWIDTH:0]   hdiff;
   logic signed [HWIDTH-1:0] hnext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // crash outranks pause, pause outranks start
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (bus.start) state_d = S_RUN;
         S_RUN:    if (bus.crash) state_d = S_DEAD;
                   else if (bus.pause) state_d = S_PAUSED;
         S_PAUSED: if (bus.crash) state_d = S_DEAD;
                   else if (bus.start) state_d = S_RUN;
         S_DEAD:   if (bus.start) state_d = S_RUN;
         default:  state_d = S_IDLE;
      endcase
   end

   assign restart   = (state_q == S_DEAD) && bus.start;
   assign frame_upd = (state_q == S_RUN) && bus.frame_start && !bus.crash;
   assign lane_ok   = (state_q == S_RUN) && !bus.crash;

   // speed is zero-extended, voffset sign-extended, one guard bit for the borrow
   always_comb begin
      vdiff = {voff_q[VWIDTH-1], voff_q} - $signed({{(VWIDTH+1-SPEED_W){1'b0}}, speed_q});
      vnext = vdiff[VWIDTH-1:0];
`ifdef SCROLL_WRAP_EN
      if (vdiff < 0) vnext = VWIDTH'(vdiff + VSPAN_V);
`endif
   end

   always_comb begin
      case (lane_q)
         2'd0:    target = -LANE_W_V;
         2'd2:    target = LANE_W_V;
         default: target = '0;
      endcase
      hdiff = {target[HWIDTH-1], target} - {hoff_q[HWIDTH-1], hoff_q};
      if (hdiff > STEP_E)       hnext = hoff_q + STEP_V;
      else if (hdiff < -STEP_E) hnext = hoff_q - STEP_V;
      else                      hnext = target;
   end

   always_comb begin
      hoff_d  = hoff_q;
      voff_d  = voff_q;
      speed_d = speed_q;
      lane_d  = lane_q;
      fcnt_d  = fcnt_q;
      acc_d   = acc_q;
      if (restart) begin
         hoff_d  = '0;
         voff_d  = '0;
         speed_d = SPEED_INIT_V;
         lane_d  = 2'd1;
         fcnt_d  = '0;
         acc_d   = '0;
      end else begin
         if (frame_upd) begin
            voff_d = vnext;
            hoff_d = hnext;
            fcnt_d = fcnt_q + 16'd1;
            if (acc_q == ACC_LAST) begin
               acc_d = '0;
               if (speed_q < SPEED_MAX_V) speed_d = speed_q + 1'b1;
            end else begin
               acc_d = acc_q + 1'b1;
            end
         end
         // simultaneous left+right cancels; edge requests fall through unchanged
         if (lane_ok && (bus.lane_left != bus.lane_right)) begin
            if (bus.lane_left && lane_q != 2'd0)  lane_d = lane_q - 2'd1;
            if (bus.lane_right && lane_q != 2'd2) lane_d = lane_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hoff_q  <= '0;
         voff_q  <= '0;
         speed_q <= SPEED_INIT_V;
         lane_q  <= 2'd1;
         fcnt_q  <= '0;
         acc_q   <= '0;
      end else begin
         hoff_q  <= hoff_d;
         voff_q  <= voff_d;
         speed_q <= speed_d;
         lane_q  <= lane_d;
         fcnt_q  <= fcnt_d;
         acc_q   <= acc_d;
      end
   end

   assign bus.hoffset   = hoff_q;
   assign bus.voffset   = voff_q;
   assign bus.speed     = speed_q;
   assign bus.lane      = lane_q;
   assign bus.state     = state_q;
   assign bus.frame_cnt = fcnt_q;
endmodule
